// File: rtl/bitwise_pkg.sv
// Shared types and limits for the bit-serial bitwise unit.
package bitwise_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_slice_alu.sv
// One-bit combinational slice: OR, AND, NOT, and XOR when SERIAL_BITWISE_XOR_EN is defined.
module bit_slice_alu (
  input  logic a,
  input  logic b,
  output logic or_o,
  output logic and_o,
`ifdef SERIAL_BITWISE_XOR_EN
  output logic xor_o,
`endif
  output logic not_o
);

  assign or_o  = a | b;
  assign and_o = a & b;
  assign not_o = ~a;
`ifdef SERIAL_BITWISE_XOR_EN
  assign xor_o = a ^ b;
`endif

endmodule

// File: rtl/serial_bitwise_unit.sv
// Bit-serial OR/AND/NOT unit (plus XOR under SERIAL_BITWISE_XOR_EN), LSB first,
// with valid/ready handshakes on operands and results.
module serial_bitwise_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A_or_B,
  output logic [WIDTH-1:0] A_and_B,
  output logic [WIDTH-1:0] not_A,
`ifdef SERIAL_BITWISE_XOR_EN
  output logic [WIDTH-1:0] A_xor_B,
`endif
  output logic             busy
);

  // Counter reaches WIDTH after the last shift, so it needs WIDTH+1 codes.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             accept, release_res, last_shift;
  logic             s_or, s_and, s_not;
`ifdef SERIAL_BITWISE_XOR_EN
  logic             s_xor;
`endif

  function automatic logic [WIDTH-1:0] shift_in_msb(input logic msb, input logic [WIDTH-1:0] r);
    return (r >> 1) | (WIDTH'(msb) << (WIDTH - 1));
  endfunction

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign last_shift  = (state == SHIFT) && (bit_cnt == LAST_CNT);

  bit_slice_alu u_slice (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .or_o  (s_or),
    .and_o (s_and),
`ifdef SERIAL_BITWISE_XOR_EN
    .xor_o (s_xor),
`endif
    .not_o (s_not)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = SHIFT;
      SHIFT:   if (last_shift)  state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == SHIFT) || (state == DONE);
  end

  // Operand/result shift datapath; results are cleared only on a new accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      bit_cnt <= '0;
      A_or_B  <= '0;
      A_and_B <= '0;
      not_A   <= '0;
`ifdef SERIAL_BITWISE_XOR_EN
      A_xor_B <= '0;
`endif
    end else if (accept) begin
      a_sr    <= A;
      b_sr    <= B;
      bit_cnt <= '0;
      A_or_B  <= '0;
      A_and_B <= '0;
      not_A   <= '0;
`ifdef SERIAL_BITWISE_XOR_EN
      A_xor_B <= '0;
`endif
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      bit_cnt <= bit_cnt + CNT_W'(1);
      A_or_B  <= shift_in_msb(s_or, A_or_B);
      A_and_B <= shift_in_msb(s_and, A_and_B);
      not_A   <= shift_in_msb(s_not, not_A);
`ifdef SERIAL_BITWISE_XOR_EN
      A_xor_B <= shift_in_msb(s_xor, A_xor_B);
`endif
    end
  end

endmodule

// File: tb/tb_serial_bitwise_unit.sv
// Scoreboard bench for serial_bitwise_unit: a 4-bit and an 8-bit instance.
module tb_serial_bitwise_unit;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] a;
    logic [3:0] n;
    logic [3:0] x;
  } exp4_t;

  typedef struct packed {
    logic [7:0] o;
    logic [7:0] a;
    logic [7:0] n;
    logic [7:0] x;
  } exp8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, busy;
  logic [3:0] A = '0, B = '0;
  logic [3:0] or4, and4, not4;
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic       in_ready8, out_valid8, busy8;
  logic [7:0] A8 = '0, B8 = '0;
  logic [7:0] or8, and8, not8;
`ifdef SERIAL_BITWISE_XOR_EN
  logic [3:0] xor4;
  logic [7:0] xor8;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp4_t q4[$];
  exp8_t q8[$];

  always #5 clk = ~clk;

  serial_bitwise_unit #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .A_or_B(or4), .A_and_B(and4), .not_A(not4),
`ifdef SERIAL_BITWISE_XOR_EN
    .A_xor_B(xor4),
`endif
    .busy(busy)
  );

  serial_bitwise_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
    .A_or_B(or8), .A_and_B(and8), .not_A(not8),
`ifdef SERIAL_BITWISE_XOR_EN
    .A_xor_B(xor8),
`endif
    .busy(busy8)
  );

  function automatic exp4_t model4(input logic [3:0] a, input logic [3:0] b);
    exp4_t e;
    e.o = a | b; e.a = a & b; e.n = ~a; e.x = a ^ b;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if ({or4, and4, not4} !== 12'h000) begin n_fail++; $display("FAIL reset_results got %h want 000", {or4, and4, not4}); end
    n_checks++; if ({in_ready8, out_valid8, busy8} !== 3'b100) begin n_fail++; $display("FAIL reset_w8_ctrl got %b want 100", {in_ready8, out_valid8, busy8}); end
  endtask

  task automatic test_basic();
    exp4_t e;
    int    early;
    @(negedge clk);
    A = 4'b1010; B = 4'b0101; in_valid = 1'b1; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
    q4.push_back(model4(A, B));
    @(posedge clk);
    #1 in_valid = 1'b0; A = '0; B = '0;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL basic_latency_early got %0d early valids want 0", early); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    e = (q4.size() > 0) ? q4.pop_front() : '0;
    n_checks++; if (or4 !== e.o) begin n_fail++; $display("FAIL basic_or got %b want %b", or4, e.o); end
    n_checks++; if (and4 !== e.a) begin n_fail++; $display("FAIL basic_and got %b want %b", and4, e.a); end
    n_checks++; if (not4 !== e.n) begin n_fail++; $display("FAIL basic_not got %b want %b", not4, e.n); end
`ifdef SERIAL_BITWISE_XOR_EN
    n_checks++; if (xor4 !== e.x) begin n_fail++; $display("FAIL basic_xor got %b want %b", xor4, e.x); end
`endif
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin n_fail++; $display("FAIL basic_return_idle got %b want 100", {in_ready, out_valid, busy}); end
    n_checks++; if ({or4, and4, not4} !== {e.o, e.a, e.n}) begin n_fail++; $display("FAIL basic_hold got %h want %h", {or4, and4, not4}, {e.o, e.a, e.n}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va[3] = '{4'b0000, 4'b1111, 4'b0001};
    logic [3:0] vb[3] = '{4'b0000, 4'b0000, 4'b0001};
    int    t_acc[3];
    int    idx, got, cyc;
    logic  acc;
    exp4_t e;
    @(negedge clk);
    idx = 0; got = 0; cyc = 0;
    A = va[0]; B = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        e = (q4.size() > 0) ? q4.pop_front() : '0;
        n_checks++; if ({or4, and4, not4} !== {e.o, e.a, e.n}) begin n_fail++; $display("FAIL b2b_result%0d got %h want %h", got, {or4, and4, not4}, {e.o, e.a, e.n}); end
`ifdef SERIAL_BITWISE_XOR_EN
        n_checks++; if (xor4 !== e.x) begin n_fail++; $display("FAIL b2b_xor%0d got %b want %b", got, xor4, e.x); end
`endif
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q4.push_back(model4(A, B));
        t_acc[idx] = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin A = va[idx]; B = vb[idx]; end
        else in_valid = 1'b0;
      end
      cyc++;
    end
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL b2b_timeout got %0d results want 3", got); end
    n_checks++; if (t_acc[1] - t_acc[0] != 6) begin n_fail++; $display("FAIL b2b_spacing01 got %0d want 6", t_acc[1] - t_acc[0]); end
    n_checks++; if (t_acc[2] - t_acc[1] != 6) begin n_fail++; $display("FAIL b2b_spacing12 got %0d want 6", t_acc[2] - t_acc[1]); end
  endtask

  task automatic test_backpressure();
    exp4_t e;
    int    bad;
    @(negedge clk);
    A = 4'b0110; B = 4'b0011; in_valid = 1'b1; out_ready = 1'b0;
    q4.push_back(model4(A, B));
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait_valid got %b want 1", out_valid); end
    e = (q4.size() > 0) ? q4.pop_front() : '0;
    bad = 0;
    A = 4'b1111; B = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {or4, and4, not4} !== {e.o, e.a, e.n}) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d bad cycles want 0", bad); end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if ({or4, and4, not4} !== {e.o, e.a, e.n}) begin n_fail++; $display("FAIL bp_result got %h want %h", {or4, and4, not4}, {e.o, e.a, e.n}); end
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_one_transfer got %b want 10", {in_ready, out_valid}); end
    @(negedge clk);
    n_checks++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_ignored_input got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    A = 4'b1100; B = 4'b0011; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({in_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_idle got %b want 10", {in_ready, busy}); end
    n_checks++; if ({or4, and4, not4} !== 12'h000) begin n_fail++; $display("FAIL mid_rst_results got %h want 000", {or4, and4, not4}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_rst_no_valid got %0d valids want 0", seen); end
  endtask

  task automatic test_wide();
    exp8_t e;
    int    cyc;
    @(negedge clk);
    A8 = 8'hA5; B8 = 8'h0F; in_valid8 = 1'b1; out_ready8 = 1'b1;
    e.o = A8 | B8; e.a = A8 & B8; e.n = ~A8; e.x = A8 ^ B8;
    q8.push_back(e);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    cyc = 0;
    while (out_valid8 !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc - 1 != 8) begin n_fail++; $display("FAIL wide_latency got %0d want 8", cyc - 1); end
    e = (q8.size() > 0) ? q8.pop_front() : '0;
    n_checks++; if (or8 !== e.o) begin n_fail++; $display("FAIL wide_or got %h want %h", or8, e.o); end
    n_checks++; if (and8 !== e.a) begin n_fail++; $display("FAIL wide_and got %h want %h", and8, e.a); end
    n_checks++; if (not8 !== e.n) begin n_fail++; $display("FAIL wide_not got %h want %h", not8, e.n); end
`ifdef SERIAL_BITWISE_XOR_EN
    n_checks++; if (xor8 !== e.x) begin n_fail++; $display("FAIL wide_xor got %h want %h", xor8, e.x); end
`endif
    @(negedge clk);
    n_checks++; if ({in_ready8, out_valid8} !== 2'b10) begin n_fail++; $display("FAIL wide_return_idle got %b want 10", {in_ready8, out_valid8}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
